// File: rtl/can_tx_scheduler.sv
// Purpose : round-robin scheduler that hands one channel's 32-bit frame at a time to a CAN packet controller,
//           retrying no-ack completions up to MAX_RETRY times and aborting attempts that exceed TIMEOUT cycles.
// Ports   : rstn/clk; per-channel req_valid/req_data in, req_grant out; per-channel cpl_valid plus shared cpl_status out;
//           busy out; tx_start/tx_data out to the packet controller, tx_done/tx_acked in from it.
module can_tx_scheduler #(
  parameter int          N_CH      = 4,
  parameter int          MAX_RETRY = 3,
  parameter logic [31:0] TIMEOUT   = 32'd2_000_000
) (
  input  logic                 rstn,
  input  logic                 clk,
  input  logic [N_CH-1:0]      req_valid,
  input  logic [32*N_CH-1:0]   req_data,
  output logic [N_CH-1:0]      req_grant,
  output logic [N_CH-1:0]      cpl_valid,
  output logic [1:0]           cpl_status,
  output logic                 busy,
  output logic                 tx_start,
  output logic [31:0]          tx_data,
  input  logic                 tx_done,
  input  logic                 tx_acked
);

  localparam int          CW       = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [3:0]  MAX_R    = 4'(MAX_RETRY);
  localparam logic [31:0] TMO_LAST = TIMEOUT - 32'd1;

  typedef enum logic [1:0] {IDLE, SEND, CPL} state_t;

  state_t         state;
  logic [CW-1:0]  last_granted;  // also identifies the channel in flight
  logic [3:0]     retry_cnt;
  logic [31:0]    timer;
  logic [31:0]    hold;
  logic [1:0]     status;

  logic           gnt_any;
  logic [CW-1:0]  gnt_idx;

  // Rotating-priority search starting just after the last granted channel.
  always_comb begin
    int idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = (int'(last_granted) + 1 + k) % N_CH;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = CW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      last_granted <= CW'(N_CH - 1);
      retry_cnt    <= '0;
      timer        <= '0;
      hold         <= '0;
      status       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            last_granted <= gnt_idx;
            hold         <= req_data[32*int'(gnt_idx) +: 32];
            retry_cnt    <= '0;
            timer        <= '0;
            state        <= SEND;
          end
        end
        SEND: begin
          timer <= timer + 32'd1;
          // A completion in the last timer cycle wins over the timeout.
          if (tx_done) begin
            if (tx_acked) begin
              status <= 2'd0;
              state  <= CPL;
            end else if (retry_cnt < MAX_R) begin
              retry_cnt <= retry_cnt + 4'd1;
              timer     <= '0;
            end else begin
              status <= 2'd1;
              state  <= CPL;
            end
          end else if (timer == TMO_LAST) begin
            status <= 2'd2;
            state  <= CPL;
          end
        end
        CPL:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode directly from registered state so reset clears them immediately.
  // The grant is gated with rstn so no payload is accepted while reset is held.
  always_comb begin
    req_grant = '0;
    if (state == IDLE && gnt_any && rstn)
      req_grant = N_CH'(1) << gnt_idx;
  end

  assign cpl_valid  = (state == CPL) ? (N_CH'(1) << last_granted) : '0;
  assign cpl_status = (state == CPL) ? status : 2'd0;
  assign busy       = (state != IDLE);
  assign tx_start   = (state == SEND);
  assign tx_data    = hold;

endmodule

// File: tb/tb_can_tx_scheduler.sv
module tb_can_tx_scheduler;

  localparam int N_CH = 4;

  logic                rstn;
  logic                clk;
  logic [N_CH-1:0]     req_valid;
  logic [32*N_CH-1:0]  req_data;
  logic [N_CH-1:0]     req_grant;
  logic [N_CH-1:0]     cpl_valid;
  logic [1:0]          cpl_status;
  logic                busy;
  logic                tx_start;
  logic [31:0]         tx_data;
  logic                tx_done;
  logic                tx_acked;

  int vectors;
  int miscompares;

  can_tx_scheduler #(.N_CH(N_CH), .MAX_RETRY(3), .TIMEOUT(32'd100)) dut (
    .rstn(rstn), .clk(clk), .req_valid(req_valid), .req_data(req_data),
    .req_grant(req_grant), .cpl_valid(cpl_valid), .cpl_status(cpl_status),
    .busy(busy), .tx_start(tx_start), .tx_data(tx_data),
    .tx_done(tx_done), .tx_acked(tx_acked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 2 time units after each rising edge.
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  // Serve one acked frame from a channel that is expected to win now.
  task automatic do_frame(input int ch);
    logic [N_CH-1:0] oh;
    oh = N_CH'(1) << ch;
    #1;
    chk($sformatf("rr_grant_ch%0d", ch), 64'(req_grant), 64'(oh));
    tick();
    chk("rr_tx_start", 64'(tx_start), 64'd1);
    tx_done = 1'b1; tx_acked = 1'b1;
    tick();
    tx_done = 1'b0; tx_acked = 1'b0;
    chk($sformatf("rr_cpl_ch%0d", ch), 64'(cpl_valid), 64'(oh));
    tick();
  endtask

  initial begin
    int n;
    vectors = 0; miscompares = 0;
    rstn = 1'b0; req_valid = 4'b1111; req_data = '1;
    tx_done = 1'b0; tx_acked = 1'b0;

    // Reset state with requests pending: nothing may be granted or driven.
    tick();
    chk("rst_grant", 64'(req_grant), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_tx_start", 64'(tx_start), 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_cpl_valid", 64'(cpl_valid), 64'd0);
    chk("rst_cpl_status", 64'(cpl_status), 64'd0);
    req_valid = '0; req_data = '0;
    rstn = 1'b1;
    tick();

    // Single acked frame, payload changed after the grant.
    req_valid = 4'b0001; req_data[31:0] = 32'hDEADBEEF;
    #1;
    chk("a_grant", 64'(req_grant), 64'h1);
    tick();
    req_valid = '0; req_data[31:0] = 32'h12345678;
    #1;
    chk("a_tx_start", 64'(tx_start), 64'd1);
    chk("a_tx_data", 64'(tx_data), 64'hDEADBEEF);
    chk("a_busy", 64'(busy), 64'd1);
    chk("a_grant_low", 64'(req_grant), 64'd0);
    for (int i = 0; i < 10; i++) tick();
    chk("a_tx_start_held", 64'(tx_start), 64'd1);
    tx_done = 1'b1; tx_acked = 1'b1;
    tick();
    tx_done = 1'b0; tx_acked = 1'b0;
    chk("a_cpl_valid", 64'(cpl_valid), 64'h1);
    chk("a_cpl_status", 64'(cpl_status), 64'd0);
    chk("a_cpl_tx_start", 64'(tx_start), 64'd0);
    tick();
    chk("a_idle_busy", 64'(busy), 64'd0);
    chk("a_idle_cpl", 64'(cpl_valid), 64'd0);

    // Completion pulses while idle are ignored.
    tx_done = 1'b1; tx_acked = 1'b1;
    tick();
    tx_done = 1'b0; tx_acked = 1'b0;
    chk("idle_done_busy", 64'(busy), 64'd0);
    chk("idle_done_cpl", 64'(cpl_valid), 64'd0);

    // Round robin with all channels requesting from a fresh reset: 0,1,2,3,0.
    do_reset();
    req_valid = 4'b1111;
    do_frame(0);
    do_frame(1);
    do_frame(2);
    do_frame(3);
    do_frame(0);
    req_valid = '0;
    tick();

    // No-ack on every attempt: three retries, then status 1 (last granted 0, so ch1 next).
    req_valid = 4'b0010;
    #1;
    chk("r_grant", 64'(req_grant), 64'h2);
    tick();
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("r_tx_start_%0d", k), 64'(tx_start), 64'd1);
      tx_done = 1'b1; tx_acked = 1'b0;
      tick();
      tx_done = 1'b0;
      if (k < 3) chk($sformatf("r_no_cpl_%0d", k), 64'(cpl_valid), 64'd0);
    end
    chk("r_cpl_valid", 64'(cpl_valid), 64'h2);
    chk("r_cpl_status", 64'(cpl_status), 64'd1);
    chk("r_tx_start_low", 64'(tx_start), 64'd0);
    tick();

    // Timeout: tx_start held exactly 100 cycles, then status 2 on ch2.
    req_valid = 4'b0100;
    #1;
    chk("t_grant", 64'(req_grant), 64'h4);
    tick();
    req_valid = '0;
    n = 0;
    while (tx_start && n < 200) begin
      n++;
      tick();
    end
    chk("t_high_cycles", 64'(n), 64'd100);
    chk("t_cpl_valid", 64'(cpl_valid), 64'h4);
    chk("t_cpl_status", 64'(cpl_status), 64'd2);
    tick();

    // Ack in the very cycle the timer hits its last value: ack wins (ch3).
    req_valid = 4'b1000;
    #1;
    chk("b_grant", 64'(req_grant), 64'h8);
    tick();
    req_valid = '0;
    for (int i = 0; i < 99; i++) tick();
    chk("b_tx_start_last", 64'(tx_start), 64'd1);
    tx_done = 1'b1; tx_acked = 1'b1;
    tick();
    tx_done = 1'b0; tx_acked = 1'b0;
    chk("b_cpl_valid", 64'(cpl_valid), 64'h8);
    chk("b_cpl_status", 64'(cpl_status), 64'd0);
    tick();

    // Reset mid-SEND on ch0 (last granted 3): immediate drop, no completion, ch0 wins after release.
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0100;
    tick();
    tick();
    // ch2 now pending; rotate so ch2 would otherwise win after ch0 was granted.
    chk("m_tx_start_pre", 64'(tx_start), 64'd1);
    rstn = 1'b0;
    #1;
    chk("m_tx_start_async", 64'(tx_start), 64'd0);
    chk("m_busy_async", 64'(busy), 64'd0);
    tick();
    chk("m_no_cpl", 64'(cpl_valid), 64'd0);
    req_valid = 4'b1111;
    rstn = 1'b1;
    #1;
    chk("m_grant_after", 64'(req_grant), 64'h1);
    tick();
    req_valid = '0;
    chk("m_no_cpl_after", 64'(cpl_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/can_tx_scheduler.md
CAN_TX_SCHEDULER -- requirements
Module: can_tx_scheduler

Interface
REQ-001 Parameter N_CH, default 4, number of requester channels (2..8).
REQ-002 Parameter MAX_RETRY, default 3, retries allowed after a non-acked tx_done (0..15).
REQ-003 Parameter TIMEOUT, default 32'd2_000_000, clk cycles allowed per attempt before abort (>=1).
REQ-004 Ports, in order:
- rstn  input  1  active-low reset.
- clk  input  1  system clock.
- req_valid  input  N_CH  per-channel request, level.
- req_data  input  32*N_CH  channel i payload in bits [32i+31:32i].
- req_grant  output  N_CH  one-hot one-cycle pulse; payload accepted.
- cpl_valid  output  N_CH  one-hot one-cycle completion pulse.
- cpl_status  output  2  valid with cpl_valid: 0 acked, 1 no-ack retries exhausted, 2 timeout.
- busy  output  1  high outside IDLE.
- tx_start  output  1  to packet controller, level.
- tx_data  output  32  to packet controller.
- tx_done  input  1  one-cycle pulse from packet controller.
- tx_acked  input  1  valid with tx_done.
REQ-005 The block SHALL use the single clock clk; reset SHALL be asynchronous and active-low on rstn.

Function
REQ-006 The block SHALL implement states IDLE, SEND and CPL.
REQ-007 In IDLE with any req_valid high, the block SHALL grant one channel by round-robin: the search starts at (last_granted+1) mod N_CH; last_granted resets to N_CH-1, so channel 0 wins first.
REQ-008 On grant, in that same cycle the block SHALL pulse req_grant[i], latch req_data of channel i into a 32-bit hold register, clear retry_cnt and timer, and enter SEND.
REQ-009 After a grant, the requester SHALL be allowed to change req_data or drop req_valid; later changes SHALL NOT affect the frame in flight.
REQ-010 In SEND, tx_start SHALL be 1 and tx_data SHALL equal the hold register.
REQ-011 tx_start SHALL rise the cycle after the grant.
REQ-012 Holding tx_start through lost arbitration SHALL be the retry mechanism for arbitration loss; the block SHALL NOT count arbitration loss as a retry.
REQ-013 In SEND, the 32-bit timer SHALL increment every cycle.
REQ-014 In SEND, on tx_done with tx_acked=1 the block SHALL set status 0 and enter CPL.
REQ-015 In SEND, on tx_done with tx_acked=0 and retry_cnt<MAX_RETRY, the block SHALL increment retry_cnt, clear the timer and stay in SEND with tx_start held 1.
REQ-016 In SEND, on tx_done with tx_acked=0 and retry_cnt==MAX_RETRY, the block SHALL set status 1 and enter CPL.
REQ-017 In SEND, when the timer reaches TIMEOUT-1 without tx_done, the block SHALL set status 2 and enter CPL; tx_done in that same cycle SHALL take priority over the timeout.
REQ-018 In CPL, tx_start SHALL be 0; the block SHALL pulse cpl_valid[granted] with cpl_status for exactly one cycle and then return to IDLE.
REQ-019 tx_start SHALL be low for at least one cycle between frames.
REQ-020 tx_done or tx_acked arriving in IDLE or CPL SHALL be ignored.
REQ-021 At most one channel SHALL be in flight; req_grant and cpl_valid SHALL never have more than one bit set.
REQ-022 busy SHALL be 1 in SEND and CPL, and 0 in IDLE.
REQ-023 The earliest next grant SHALL be the IDLE cycle after CPL; minimum spacing between grants is 3 cycles.

Reset
REQ-024 While rstn=0, state=IDLE, last_granted=N_CH-1, retry_cnt=0, timer=0, hold=0, and outputs SHALL be 0: req_grant, cpl_valid, cpl_status, busy, tx_start, tx_data.
REQ-025 An assertion of rstn mid-SEND SHALL drop tx_start immediately (asynchronously) and SHALL emit no cpl_valid for the aborted channel.

Verification
REQ-026 Scenario: req_valid=4'b0001, req_data[31:0]=32'hDEADBEEF, tx_done/tx_acked=1 ten cycles after tx_start -> req_grant=0001, tx_data=32'hDEADBEEF, then cpl_valid=0001 with status 0 and tx_start low.
REQ-027 Scenario: req_valid=4'b1111 held, every frame acked -> grants occur in the order 0,1,2,3,0.
REQ-028 Scenario: MAX_RETRY=3, every tx_done has tx_acked=0 -> four tx_done pulses with tx_start continuously 1, then cpl_status=1.
REQ-029 Scenario: TIMEOUT=100, no tx_done -> tx_start is high for exactly 100 cycles, then cpl_status=2.
REQ-030 Scenario: tx_done arrives in the same cycle the timer reaches TIMEOUT-1 -> ack status is reported and timeout is not.
REQ-031 Scenario: rstn pulsed low during SEND -> tx_start=0 at once, no cpl_valid, and after release channel 0 wins the next grant.
